instr_fetch: RTL and testbench

Instruction fetch stage between the program counter and decode. Takes the current PC, issues word reads to instruction memory over a request/grant port with in-order, variable-latency responses, and buffers each returned instruction together with its PC in a small queue presented to decode under valid/ready. It also tells the PC when to advance, and discards in-flight and buffered work when a branch redirect occurs.

---
 rtl/fetch_pkg.sv | 17 +
 rtl/instr_fetch_if.sv | 21 ++
 rtl/fetch_fifo.sv | 48 ++++
 rtl/instr_fetch.sv | 87 ++++++++
 tb/tb_instr_fetch.sv | 290 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// Shared types and sizing helpers for the instruction fetch stage.
package fetch_pkg;

    localparam int XLEN          = 32;
    localparam int DEPTH_DEFAULT = 2;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

    // Width of an occupancy count that must hold 0..depth inclusive.
    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Instruction memory request/grant port with in-order, variable-latency responses.
interface instr_fetch_if;
    import fetch_pkg::*;

    logic            imemReq_o;
    logic [XLEN-1:0] imemAddr_o;
    logic            imemGnt_i;
    logic            imemRvalid_i;
    logic [XLEN-1:0] imemRdata_i;

    modport master (
        output imemReq_o, imemAddr_o,
        input  imemGnt_i, imemRvalid_i, imemRdata_i
    );

    modport slave (
        input  imemReq_o, imemAddr_o,
        output imemGnt_i, imemRvalid_i, imemRdata_i
    );

endinterface

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with asynchronous reset and synchronous clear.
// The head entry is presented combinationally; DEPTH must be a power of two.
module fetch_fifo #(
    parameter int  DEPTH = 2,
    parameter type T     = logic [31:0]
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_clr,
    input  logic                   i_push,
    input  T                       i_data,
    input  logic                   i_pop,
    output T                       o_data,
    output logic [$clog2(DEPTH):0] o_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    T                r_mem [DEPTH];
    logic [AW-1:0]   r_wr;
    logic [AW-1:0]   r_rd;
    logic [CW-1:0]   r_count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
            // NOTE: storage is reset too, so the head reads zero while in reset.
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (i_clr) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_wr] <= i_data;
                r_wr        <= r_wr + AW'(1);
            end
            if (i_pop) r_rd <= r_rd + AW'(1);
            r_count <= r_count + CW'(i_push) - CW'(i_pop);
        end
    end

    assign o_data  = r_mem[r_rd];
    assign o_count = r_count;

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: credit-limited word reads to instruction memory, an in-order
// {pc, instr} buffer toward decode, and drop accounting for branch redirects.
module instr_fetch
    import fetch_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [XLEN-1:0]   pc_i,
    output logic              pcEn_o,
    input  logic              redirect_i,
    instr_fetch_if.master     imem,
    output logic              instrValid_o,
    output logic [XLEN-1:0]   instr_o,
    output logic [XLEN-1:0]   instrPc_o,
    input  logic              instrReady_i
);
    localparam int CW = cnt_w(DEPTH);
    localparam int SW = CW + 1;

    logic [CW-1:0]   w_inflight;
    logic [CW-1:0]   w_count;
    logic [CW-1:0]   r_drop;
    logic [SW-1:0]   w_credit_sum;
    logic            w_pop;
    logic            w_issue;
    logic            w_resp;
    logic            w_keep;
    logic [XLEN-1:0] w_resp_pc;
    fetch_entry_t    w_head;
    fetch_entry_t    w_push_entry;

    assign w_pop        = instrValid_o & instrReady_i;
    // Extra headroom bit keeps inflight + count - pop from wrapping.
    assign w_credit_sum = SW'(w_inflight) + SW'(w_count) - SW'(w_pop);

    assign imem.imemReq_o  = rst & ~redirect_i & (w_credit_sum < SW'(DEPTH));
    assign imem.imemAddr_o = {pc_i[XLEN-1:2], 2'b00};
    assign w_issue         = imem.imemReq_o & imem.imemGnt_i;
    assign pcEn_o          = w_issue;

    // A response with nothing outstanding is ignored.
    assign w_resp = imem.imemRvalid_i & (w_inflight != '0);
    assign w_keep = w_resp & (r_drop == '0) & ~redirect_i;

    assign w_push_entry = '{pc: w_resp_pc, instr: imem.imemRdata_i};

    assign instrValid_o = (w_count != '0) & ~redirect_i;
    assign instr_o      = w_head.instr;
    assign instrPc_o    = w_head.pc;

    // The address FIFO occupancy is the inflight count.
    fetch_fifo #(.DEPTH(DEPTH), .T(logic [XLEN-1:0])) u_addr_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (1'b0),
        .i_push  (w_issue),
        .i_data  (pc_i),
        .i_pop   (w_resp),
        .o_data  (w_resp_pc),
        .o_count (w_inflight)
    );

    fetch_fifo #(.DEPTH(DEPTH), .T(fetch_entry_t)) u_instr_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (redirect_i),
        .i_push  (w_keep),
        .i_data  (w_push_entry),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_count (w_count)
    );

    // Responses still owed for the abandoned path are counted down and discarded.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_drop <= '0;
        end else if (redirect_i) begin
            r_drop <= w_inflight - CW'(w_resp);
        end else if (w_resp && (r_drop != '0)) begin
            r_drop <= r_drop - CW'(1);
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: queue-based reference model, in-order
// variable-latency memory model, directed scenarios and a randomized run.
module tb_instr_fetch;
    import fetch_pkg::*;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_i;
    logic        pcEn_o;
    logic        redirect_i;
    logic        instrValid_o;
    logic [31:0] instr_o;
    logic [31:0] instrPc_o;
    logic        instrReady_i;

    instr_fetch_if bus ();

    instr_fetch #(.DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .pc_i         (pc_i),
        .pcEn_o       (pcEn_o),
        .redirect_i   (redirect_i),
        .imem         (bus),
        .instrValid_o (instrValid_o),
        .instr_o      (instr_o),
        .instrPc_o    (instrPc_o),
        .instrReady_i (instrReady_i)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return (a << 5) + 32'h0000_0013;
    endfunction

    // Environment state: PC register, memory response queue, cycle count.
    typedef struct { logic [31:0] addr; int due; } mreq_t;
    mreq_t       memq[$];
    logic [31:0] bpc = '0;
    logic [31:0] redir_target = '0;
    int          cyc = 0;
    int          last_due = 0;
    int          lat = 1;
    int          delivered = 0;

    // Reference model: outstanding requests (stale after redirect) and the buffer.
    typedef struct { logic [31:0] pc; bit stale; } fly_t;
    fly_t         flyq[$];
    fetch_entry_t bufq[$];

    always @(negedge clk) begin
        bit   exp_valid, exp_pop, exp_req, exp_issue;
        fly_t f;
        int   due;
        if (!rst) begin
            flyq.delete();
            bufq.delete();
            memq.delete();
            bpc      = '0;
            last_due = 0;
            check("rst_req",    {31'b0, bus.imemReq_o}, 32'd0);
            check("rst_pcen",   {31'b0, pcEn_o},        32'd0);
            check("rst_valid",  {31'b0, instrValid_o},  32'd0);
            check("rst_instr",  instr_o,                32'd0);
            check("rst_instrpc", instrPc_o,             32'd0);
        end else begin
            exp_valid = (bufq.size() != 0) && !redirect_i;
            exp_pop   = exp_valid && instrReady_i;
            exp_req   = !redirect_i &&
                        ((flyq.size() + bufq.size() - (exp_pop ? 1 : 0)) < DEPTH);
            exp_issue = exp_req && bus.imemGnt_i;

            check("req",   {31'b0, bus.imemReq_o}, {31'b0, exp_req});
            check("pcen",  {31'b0, pcEn_o},        {31'b0, exp_issue});
            check("addr",  bus.imemAddr_o,         {pc_i[31:2], 2'b00});
            check("valid", {31'b0, instrValid_o},  {31'b0, exp_valid});
            if (exp_valid) begin
                check("head_pc",    instrPc_o, bufq[0].pc);
                check("head_instr", instr_o,   bufq[0].instr);
            end

            if (bus.imemRvalid_i)
                assert (flyq.size() != 0)
                else $error("FAIL protocol: response with nothing in flight");

            // Model update.
            if (bus.imemRvalid_i && flyq.size() != 0) begin
                f = flyq.pop_front();
                if (!f.stale && !redirect_i)
                    bufq.push_back('{pc: f.pc, instr: bus.imemRdata_i});
            end
            if (redirect_i) begin
                foreach (flyq[i]) flyq[i].stale = 1'b1;
                bufq.delete();
            end else if (exp_pop) begin
                void'(bufq.pop_front());
                delivered++;
            end
            if (exp_issue) flyq.push_back('{pc: pc_i, stale: 1'b0});

            // Environment update, driven by what the bus actually did.
            if (bus.imemRvalid_i && memq.size() != 0) void'(memq.pop_front());
            if (bus.imemReq_o && bus.imemGnt_i) begin
                due = cyc + lat;
                if (due <= last_due) due = last_due + 1;
                last_due = due;
                memq.push_back('{addr: {pc_i[31:2], 2'b00}, due: due});
            end
            if (redirect_i)  bpc = redir_target;
            else if (pcEn_o) bpc = bpc + 32'd4;
        end
        cyc++;
    end

    // One clock cycle of stimulus; returns 2 time units after the rising edge.
    task automatic step(input bit rdy, input bit gnt, input bit redir, input logic [31:0] tgt);
        @(posedge clk);
        #1;
        rst             = 1'b1;
        pc_i            = bpc;
        redirect_i      = redir;
        redir_target    = tgt;
        instrReady_i    = rdy;
        bus.imemGnt_i   = gnt;
        if (memq.size() != 0 && memq[0].due <= cyc) begin
            bus.imemRvalid_i = 1'b1;
            bus.imemRdata_i  = mem_data(memq[0].addr);
        end else begin
            bus.imemRvalid_i = 1'b0;
            bus.imemRdata_i  = $urandom;
        end
        #1;
    endtask

    task automatic reset_dut();
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        bit          seen_new, saw_stale;
        logic [31:0] first_pc;

        rst              = 1'b0;
        pc_i             = '0;
        redirect_i       = 1'b0;
        instrReady_i     = 1'b0;
        bus.imemGnt_i    = 1'b0;
        bus.imemRvalid_i = 1'b0;
        bus.imemRdata_i  = '0;
        #1;
        check("reset_req",     {31'b0, bus.imemReq_o}, 32'd0);
        check("reset_valid",   {31'b0, instrValid_o},  32'd0);
        check("reset_instr",   instr_o,                32'd0);
        check("reset_instrpc", instrPc_o,              32'd0);
        reset_dut();

        // Streaming at L=1.
        lat = 1;
        for (int c = 1; c <= 10; c++) begin
            step(1, 1, 0, '0);
            check("stream_req", {31'b0, bus.imemReq_o}, 32'd1);
            if (c >= 3 && c <= 6) begin
                check("stream_valid", {31'b0, instrValid_o}, 32'd1);
                check("stream_pc",    instrPc_o, 32'((c - 3) * 4));
            end
        end

        // Backpressure: buffer fills, PC holds, stream resumes in order.
        reset_dut();
        for (int c = 1; c <= 5; c++) step(0, 1, 0, '0);
        check("bp_req",        {31'b0, bus.imemReq_o}, 32'd0);
        check("bp_pcen",       {31'b0, pcEn_o},        32'd0);
        check("bp_head_pc",    instrPc_o,              32'h0);
        check("bp_head_instr", instr_o,                32'h0000_0013);
        for (int c = 6; c <= 8; c++) begin
            step(1, 1, 0, '0);
            check("bp_resume_valid", {31'b0, instrValid_o}, 32'd1);
            check("bp_resume_pc",    instrPc_o, 32'((c - 6) * 4));
        end

        // Asynchronous reset with a full buffer.
        reset_dut();
        for (int c = 1; c <= 5; c++) step(0, 1, 0, '0);
        step(1, 1, 0, '0);
        check("arst_pre_valid", {31'b0, instrValid_o}, 32'd1);
        check("arst_pre_pcen",  {31'b0, pcEn_o},       32'd1);
        #1;
        rst = 1'b0;
        #1;
        check("arst_valid", {31'b0, instrValid_o},  32'd0);
        check("arst_req",   {31'b0, bus.imemReq_o}, 32'd0);
        check("arst_pcen",  {31'b0, pcEn_o},        32'd0);
        reset_dut();

        // Redirect with 0x8 and 0xC outstanding at L=3.
        lat = 3;
        for (int c = 1; c <= 6; c++) begin
            step(1, 1, 0, '0);
            if (c == 5) begin
                check("rd_pc5",   instrPc_o,      32'h0);
                check("rd_addr5", bus.imemAddr_o, 32'h8);
                check("rd_pcen5", {31'b0, pcEn_o}, 32'd1);
            end
            if (c == 6) begin
                check("rd_pc6",   instrPc_o,      32'h4);
                check("rd_addr6", bus.imemAddr_o, 32'hC);
                check("rd_pcen6", {31'b0, pcEn_o}, 32'd1);
            end
        end
        step(1, 1, 1, 32'h100);
        check("rd_redir_req",  {31'b0, bus.imemReq_o}, 32'd0);
        check("rd_redir_pcen", {31'b0, pcEn_o},        32'd0);
        seen_new  = 1'b0;
        saw_stale = 1'b0;
        first_pc  = '0;
        for (int c = 0; c < 30 && !seen_new; c++) begin
            step(1, 1, 0, '0);
            if (instrValid_o) begin
                if (instrPc_o == 32'h8 || instrPc_o == 32'hC) saw_stale = 1'b1;
                if (!saw_stale) begin
                    seen_new = 1'b1;
                    first_pc = instrPc_o;
                end
            end
        end
        check("rd_no_stale",   {31'b0, saw_stale}, 32'd0);
        check("rd_delivered",  {31'b0, seen_new},  32'd1);
        check("rd_first_pc",   first_pc,           32'h100);
        lat = 1;

        // Redirect coinciding with a response and a pop.
        reset_dut();
        step(1, 1, 0, '0);
        step(1, 1, 0, '0);
        step(1, 1, 1, 32'h200);
        check("rrp_valid", {31'b0, instrValid_o},  32'd0);
        check("rrp_resp",  {31'b0, bus.imemRvalid_i}, 32'd1);
        step(1, 1, 0, '0);
        check("rrp_empty", {31'b0, instrValid_o},  32'd0);
        check("rrp_req",   {31'b0, bus.imemReq_o}, 32'd1);
        check("rrp_addr",  bus.imemAddr_o,         32'h200);
        step(1, 1, 0, '0);
        step(1, 1, 0, '0);
        check("rrp_new_pc",    instrPc_o, 32'h200);
        check("rrp_new_instr", instr_o,   mem_data(32'h200));

        // Grant stalls.
        reset_dut();
        for (int c = 1; c <= 4; c++) begin
            step(1, 0, 0, '0);
            check("gs_addr", bus.imemAddr_o,         32'h0);
            check("gs_pcen", {31'b0, pcEn_o},        32'd0);
            check("gs_req",  {31'b0, bus.imemReq_o}, 32'd1);
        end
        step(1, 1, 0, '0);
        check("gs_grant_pcen", {31'b0, pcEn_o}, 32'd1);
        step(1, 0, 0, '0);
        check("gs_after_pcen", {31'b0, pcEn_o}, 32'd0);
        check("gs_after_addr", bus.imemAddr_o,  32'h4);

        // Randomized traffic against the model.
        reset_dut();
        delivered = 0;
        for (int c = 0; c < 4000; c++) begin
            if (c % 50 == 0) lat = int'($urandom_range(1, 4));
            step($urandom_range(99) < 75, $urandom_range(99) < 70,
                 $urandom_range(99) < 4, $urandom & 32'h0000_FFFC);
        end
        check("random_progress", {31'b0, delivered > 500}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
